// File: rtl/ltc2145_pkg.sv
// Shared types and constants for the LTC2145 per-channel sample capture path.

package ltc2145_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2,
    FAIL   = 2'd3
  } capture_state_t;

  localparam int unsigned PAT_W     = 14;
  localparam int unsigned ERR_CNT_W = 16;

  // LTC2145 alternating test pattern
  localparam logic [PAT_W-1:0] PAT_A = 14'h2AAA;
  localparam logic [PAT_W-1:0] PAT_B = 14'h1555;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ltc2145_sample_fifo.sv
// Synchronous first-word-fallthrough FIFO with flush; pointers carry one extra wrap bit.

module ltc2145_sample_fifo #(
  parameter int unsigned DW         = 14,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic          rd_ok;
  logic          wr_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_ok = rd_en & ~empty;
  // A write into a full FIFO is still taken when the head leaves in the same cycle.
  assign wr_ok = wr_en & (~full | rd_ok) & ~flush;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ltc2145_sample_capture.sv
// Per-channel LTC2145 capture: input pipe, training lock FSM, FIFO-buffered valid/ready output.
// Optional CAPTURE_TWOS_COMP_EN converts the output word from offset binary to two's complement.

module ltc2145_sample_capture
  import ltc2145_pkg::*;
#(
  parameter int unsigned DW            = 14,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned LOCK_COUNT    = 64,
  parameter int unsigned TRAIN_TIMEOUT = 4096
) (
  input  logic                 sample_clk,
  input  logic                 reset,
  input  logic [DW-1:0]        data_in,
  input  logic                 train_start,
  input  logic                 capture_en,
  output logic [DW-1:0]        m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 locked,
  output logic                 train_fail,
  output logic                 overflow,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [1:0]           state_o
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned TW = $clog2(TRAIN_TIMEOUT);
  localparam logic [DW-1:0] PAT_A_W = DW'(PAT_A);
  localparam logic [DW-1:0] PAT_B_W = DW'(PAT_B);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst;

  capture_state_t       state_q, state_d;
  logic [DW-1:0]        s1_q, s2_q, prev_q, prev_d;
  logic                 hist_vld_q, hist_vld_d;
  logic [MW-1:0]        match_q, match_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 ovf_q, ovf_d;
  logic                 locked_q, locked_d;
  logic                 fail_q, fail_d;

  logic                 good_c, lock_hit_c, tmo_hit_c;
  logic                 fifo_wr_c, fifo_rd_c, fifo_full, fifo_empty;
  logic [DW-1:0]        fifo_data;

  // Async assert, release synchronised to sample_clk.
  assign rst_sync_d = {rst_sync_q[0], 1'b0};
  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) rst_sync_q <= 2'b11;
    else       rst_sync_q <= rst_sync_d;
  end
  assign rst = rst_sync_q[1];

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= data_in;
      s2_q <= s1_q;
    end
  end

  assign good_c     = hist_vld_q && ((s2_q == PAT_A_W) || (s2_q == PAT_B_W)) && (s2_q != prev_q);
  assign lock_hit_c = good_c && (match_q == MW'(LOCK_COUNT - 1));
  assign tmo_hit_c  = (tmo_q == TW'(TRAIN_TIMEOUT - 1));

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Lock takes priority over timeout when both land in the same cycle.
  always_comb begin
    state_d = state_q;
    if (train_start) begin
      state_d = TRAIN;
    end else begin
      case (state_q)
        TRAIN: begin
          if (lock_hit_c)     state_d = LOCKED;
          else if (tmo_hit_c) state_d = FAIL;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    prev_d     = prev_q;
    hist_vld_d = hist_vld_q;
    match_d    = match_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    if (train_start) begin
      hist_vld_d = 1'b0;
      match_d    = '0;
      tmo_d      = '0;
      err_d      = '0;
      ovf_d      = 1'b0;
    end else begin
      if (state_q == TRAIN) begin
        prev_d     = s2_q;
        hist_vld_d = 1'b1;
        tmo_d      = tmo_q + TW'(1);
        if (good_c) begin
          match_d = match_q + MW'(1);
        end else begin
          match_d = '0;
          // First sample after train_start only seeds the compare history.
          if (hist_vld_q) err_d = sat_inc(err_q);
        end
      end
      if (fifo_wr_c && fifo_full && !fifo_rd_c) ovf_d = 1'b1;
    end
    locked_d = (state_d == LOCKED);
    fail_d   = (state_d == FAIL);
  end

  always_ff @(posedge sample_clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      hist_vld_q <= 1'b0;
      match_q    <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
      ovf_q      <= 1'b0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      hist_vld_q <= hist_vld_d;
      match_q    <= match_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      locked_q   <= locked_d;
      fail_q     <= fail_d;
    end
  end

  assign fifo_wr_c = (state_q == LOCKED) && capture_en && !train_start;
  assign fifo_rd_c = m_valid && m_ready;

  ltc2145_sample_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sample_clk),
    .rst     (rst),
    .flush   (train_start),
    .wr_en   (fifo_wr_c),
    .wr_data (s2_q),
    .rd_en   (fifo_rd_c),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid = ~fifo_empty;
`ifdef CAPTURE_TWOS_COMP_EN
  assign m_data  = fifo_empty ? '0 : (fifo_data ^ {1'b1, {(DW-1){1'b0}}});
`else
  assign m_data  = fifo_empty ? '0 : fifo_data;
`endif

  assign locked     = locked_q;
  assign train_fail = fail_q;
  assign overflow   = ovf_q;
  assign err_cnt    = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_ltc2145_sample_capture.sv
// Scoreboard bench for ltc2145_sample_capture: training lock/fail, FIFO capture, flush and reset.

module tb_ltc2145_sample_capture;
  import ltc2145_pkg::*;

  localparam int unsigned DW    = 14;
  localparam int unsigned DEPTH = 16;

  logic          sample_clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          train_start;
  logic          capture_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          locked;
  logic          train_fail;
  logic          overflow;
  logic [15:0]   err_cnt;
  logic [1:0]    state_o;

  int unsigned   n_chk = 0;
  int unsigned   n_err = 0;
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] d_h1 = '0;
  logic [DW-1:0] d_h2 = '0;
  logic          exp_ovf = 1'b0;
  logic          chk_on = 1'b0;
  logic          ph = 1'b0;

  always #5 sample_clk = ~sample_clk;

  ltc2145_sample_capture dut (
    .sample_clk  (sample_clk),
    .reset       (reset),
    .data_in     (data_in),
    .train_start (train_start),
    .capture_en  (capture_en),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .locked      (locked),
    .train_fail  (train_fail),
    .overflow    (overflow),
    .err_cnt     (err_cnt),
    .state_o     (state_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_out(input logic [DW-1:0] raw);
`ifdef CAPTURE_TWOS_COMP_EN
    return raw ^ 14'h2000;
`else
    return raw;
`endif
  endfunction

  function automatic logic [DW-1:0] alt_next();
    ph = ~ph;
    return ph ? PAT_A : PAT_B;
  endfunction

  // One clock: check stream outputs against the scoreboard, update model, advance.
  task automatic step();
    logic          rd;
    logic          full;
    logic [DW-1:0] w;
    if (chk_on) begin
      check_eq("m_valid", 32'(m_valid), 32'(sb_q.size() != 0));
      check_eq("overflow", 32'(overflow), 32'(exp_ovf));
      if (sb_q.size() == 0) check_eq("m_data_idle", 32'(m_data), 32'(0));
    end
    full = (sb_q.size() == DEPTH);
    rd   = (sb_q.size() != 0) && m_ready;
    if (rd) begin
      w = sb_q.pop_front();
      if (chk_on) check_eq("m_data", 32'(m_data), 32'(exp_out(w)));
    end
    if (train_start) begin
      sb_q.delete();
      exp_ovf = 1'b0;
    end else if (capture_en) begin
      if (!full || rd) sb_q.push_back(d_h2);
      else exp_ovf = 1'b1;
    end
    d_h2 = d_h1;
    d_h1 = data_in;
    @(posedge sample_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m_data"},  32'(m_data), 32'(0));
    check_eq({tag, "_m_valid"}, 32'(m_valid), 32'(0));
    check_eq({tag, "_locked"},  32'(locked), 32'(0));
    check_eq({tag, "_fail"},    32'(train_fail), 32'(0));
    check_eq({tag, "_ovf"},     32'(overflow), 32'(0));
    check_eq({tag, "_err"},     32'(err_cnt), 32'(0));
    check_eq({tag, "_state"},   32'(state_o), 32'(0));
  endtask

  // Clean alternating pattern: lock appears 66 cycles after the train_start cycle.
  task automatic run_lock(input string tag);
    for (int i = 0; i < 4; i++) begin
      data_in = alt_next();
      step();
    end
    train_start = 1'b1;
    data_in = alt_next();
    step();
    train_start = 1'b0;
    check_eq({tag, "_state_train"}, 32'(state_o), 32'(1));
    for (int j = 1; j <= 64; j++) begin
      data_in = alt_next();
      step();
    end
    check_eq({tag, "_not_yet_locked"}, 32'(locked), 32'(0));
    data_in = alt_next();
    step();
    check_eq({tag, "_locked"}, 32'(locked), 32'(1));
    check_eq({tag, "_state_locked"}, 32'(state_o), 32'(2));
    check_eq({tag, "_err_cnt"}, 32'(err_cnt), 32'(0));
  endtask

  initial begin
    reset = 1'b1;
    data_in = '0;
    train_start = 1'b0;
    capture_en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_reset_outputs("por");
    chk_on = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in = DW'($urandom);
      step();
    end
    check_eq("idle_state", 32'(state_o), 32'(0));

    run_lock("lock1");

    // Fill with m_ready low: 16 kept, 4 dropped.
    for (int i = 0; i < 22; i++) begin
      data_in = (i < 20) ? DW'(i) : '0;
      capture_en = (i >= 2);
      step();
    end
    capture_en = 1'b0;
    step();
    check_eq("ovf_after_fill", 32'(overflow), 32'(1));
    check_eq("full_entries", 32'(sb_q.size()), 32'(DEPTH));
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) step();

    // Streaming with m_ready high, including the MSB boundary codes.
    for (int i = 0; i < 22; i++) begin
      data_in = (i == 5) ? 14'h2000 : (i == 6) ? 14'h0000 : DW'(100 + i);
      capture_en = (i >= 2);
      step();
    end
    capture_en = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Buffer a few samples, then train_start must flush them.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_in = DW'(7 + i);
      capture_en = (i >= 2);
      step();
    end
    capture_en = 1'b0;
    check_eq("pre_flush_valid", 32'(m_valid), 32'(1));

    // Alternating with three zero samples injected; lock 64 good samples after the last.
    train_start = 1'b1;
    data_in = alt_next();
    step();
    train_start = 1'b0;
    check_eq("flush_m_valid", 32'(m_valid), 32'(0));
    check_eq("flush_ovf", 32'(overflow), 32'(0));
    check_eq("flush_state", 32'(state_o), 32'(1));
    for (int j = 1; j <= 96; j++) begin
      data_in = alt_next();
      if (j == 10 || j == 20 || j == 30) data_in = '0;
      step();
      if (j == 95) check_eq("inj_not_yet_locked", 32'(locked), 32'(0));
    end
    check_eq("inj_locked", 32'(locked), 32'(1));
    check_eq("inj_err_cnt", 32'(err_cnt), 32'(3));

    // Constant pattern never locks: FAIL 4096 cycles after entering TRAIN.
    for (int i = 0; i < 3; i++) begin
      data_in = PAT_A;
      step();
    end
    train_start = 1'b1;
    step();
    train_start = 1'b0;
    for (int j = 1; j <= 4096; j++) begin
      step();
      if (j == 4095) begin
        check_eq("tmo_not_yet_fail", 32'(train_fail), 32'(0));
        check_eq("tmo_still_train", 32'(state_o), 32'(1));
      end
    end
    check_eq("tmo_fail", 32'(train_fail), 32'(1));
    check_eq("tmo_state", 32'(state_o), 32'(3));
    check_eq("tmo_locked", 32'(locked), 32'(0));
    check_eq("tmo_err_cnt", 32'(err_cnt), 32'(4095));

    // Relock, buffer random data, then assert reset between clock edges.
    run_lock("lock2");
    for (int i = 0; i < 8; i++) begin
      data_in = DW'($urandom);
      capture_en = (i >= 2);
      step();
    end
    capture_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    sb_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < 2; i++) step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_in = DW'($urandom);
      step();
    end
    check_eq("post_rst_state", 32'(state_o), 32'(0));
    check_eq("post_rst_locked", 32'(locked), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
